// File: rtl/mips_pkg.sv
// Shared MIPS control constants: multicycle FSM state encoding and decoded opcodes.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EX     = 4'd6,
    R_WB     = 4'd7,
    BRANCH   = 4'd8,
    JUMP     = 4'd9,
    ADDI_EX  = 4'd10,
    ADDI_WB  = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  function automatic logic is_legal(input logic [5:0] op);
    return (op == OP_RTYPE) || (op == OP_LW) || (op == OP_SW) ||
           (op == OP_BEQ) || (op == OP_J) || (op == OP_ADDI);
  endfunction

endpackage

// File: rtl/multicycle_control.sv
// Moore control FSM for a multicycle MIPS datapath (lw/sw/R/beq/j/addi).
// Define MC_CTRL_MEM_WAIT_EN to let mem_ready stall FETCH, MEM_RD and MEM_WR.
module multicycle_control
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       nrst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] alu_op,
  output logic [1:0] pc_source,
  output logic [3:0] state,
  output logic       retire,
  output logic       illegal
);

  state_t cur;
  state_t nxt;
  logic   rdy;

`ifdef MC_CTRL_MEM_WAIT_EN
  assign rdy = mem_ready;
`else
  logic unused_mem_ready;
  assign unused_mem_ready = mem_ready;
  assign rdy = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!nrst) cur <= FETCH;
    else       cur <= nxt;
  end

  always_comb begin
    nxt = FETCH;
    case (cur)
      FETCH:    nxt = rdy ? DECODE : FETCH;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     nxt = R_EX;
          OP_LW, OP_SW: nxt = MEM_ADDR;
          OP_BEQ:       nxt = BRANCH;
          OP_J:         nxt = JUMP;
          OP_ADDI:      nxt = ADDI_EX;
          default:      nxt = FETCH;
        endcase
      end
      MEM_ADDR: nxt = (opcode == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD:   nxt = rdy ? MEM_WB : MEM_RD;
      MEM_WR:   nxt = rdy ? FETCH : MEM_WR;
      R_EX:     nxt = R_WB;
      ADDI_EX:  nxt = ADDI_WB;
      default:  nxt = FETCH;
    endcase
  end

  // Reset forces every output low combinationally, including the debug state.
  always_comb begin
    pc_en      = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    ir_write   = 1'b0;
    reg_write  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'b00;
    alu_op     = ALU_ADD;
    pc_source  = 2'b00;
    state      = 4'd0;
    retire     = 1'b0;
    illegal    = 1'b0;
    if (nrst) begin
      state = cur;
      case (cur)
        FETCH: begin
          mem_read  = 1'b1;
          alu_src_b = 2'b01;
          ir_write  = rdy;
          pc_en     = rdy;
        end
        DECODE: begin
          alu_src_b = 2'b11;
          illegal   = !is_legal(opcode);
        end
        MEM_ADDR, ADDI_EX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'b10;
        end
        MEM_RD: begin
          mem_read = 1'b1;
          iord     = 1'b1;
        end
        MEM_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
        end
        MEM_WR: begin
          mem_write = 1'b1;
          iord      = 1'b1;
          retire    = rdy;
        end
        R_EX: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_FUNCT;
        end
        R_WB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
        end
        ADDI_WB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
        end
        BRANCH: begin
          alu_src_a = 1'b1;
          alu_op    = ALU_SUB;
          pc_source = 2'b01;
          pc_en     = zero;
          retire    = 1'b1;
        end
        JUMP: begin
          pc_source = 2'b10;
          pc_en     = 1'b1;
          retire    = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 SHALL have port clk input 1: single clock; all state changes on rising edge.
REQ-002 SHALL have port nrst input 1: reset, synchronous, active-low.
REQ-003 SHALL have port opcode input 6: instruction-register bits [31:26].
REQ-004 SHALL have port zero input 1: ALU zero flag.
REQ-005 SHALL have port mem_ready input 1: memory access completes this cycle.
REQ-006 SHALL have outputs pc_en, iord, mem_read, mem_write, ir_write, reg_write, reg_dst, mem_to_reg and alu_src_a, each 1 bit: datapath enables and mux selects.
REQ-007 SHALL have outputs alu_src_b 2, alu_op 2 and pc_source 2: datapath selects and ALU operation class.
REQ-008 SHALL have output state 4: current FSM state (debug).
REQ-009 SHALL have outputs retire 1 and illegal 1: single-cycle pulses.

Function
REQ-010 SHALL implement a Moore FSM; all outputs are decoded from state, except pc_en, ir_write and retire, which also depend on zero and mem_ready.
REQ-011 SHALL use state codes FETCH=0, DECODE=1, MEM_ADDR=2, MEM_RD=3, MEM_WB=4, MEM_WR=5, R_EX=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11; codes 12-15 SHALL go to FETCH.
REQ-012 FETCH SHALL assert mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=00 and pc_source=00; ir_write and pc_en SHALL assert only when mem_ready=1, and the state SHALL advance to DECODE only then.
REQ-013 DECODE SHALL drive alu_src_a=0, alu_src_b=11, alu_op=00 and SHALL branch on opcode: 000000->R_EX, 100011/101011->MEM_ADDR, 000100->BRANCH, 000010->JUMP, 001000->ADDI_EX, other->FETCH with illegal=1 for one cycle.
REQ-014 MEM_ADDR SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00 and go to MEM_RD for lw or MEM_WR for sw.
REQ-015 MEM_RD (mem_read=1, iord=1) and MEM_WR (mem_write=1, iord=1) SHALL hold until mem_ready=1, then go to MEM_WB and FETCH respectively.
REQ-016 MEM_WB SHALL assert reg_write=1, reg_dst=0 and mem_to_reg=1.
REQ-017 R_EX SHALL drive alu_src_a=1, alu_src_b=00, alu_op=10; R_WB SHALL assert reg_write=1, reg_dst=1, mem_to_reg=0.
REQ-018 ADDI_EX SHALL drive alu_src_a=1, alu_src_b=10, alu_op=00; ADDI_WB SHALL assert reg_write=1, reg_dst=0, mem_to_reg=0.
REQ-019 BRANCH SHALL drive alu_src_a=1, alu_src_b=00, alu_op=01, pc_source=01 and pc_en=zero.
REQ-020 JUMP SHALL drive pc_source=10 and pc_en=1.
REQ-021 retire SHALL pulse on the final cycle of each legal instruction: MEM_WB, R_WB, ADDI_WB, BRANCH, JUMP, and MEM_WR when mem_ready=1.
REQ-022 Latencies SHALL be, with zero wait states: lw 5 cycles; sw, R-type and addi 4 cycles; beq and j 3 cycles.
REQ-023 Every non-terminal state not named above SHALL advance unconditionally to its successor; terminal states SHALL return to FETCH.
REQ-024 Any output not specified for a state SHALL be 0.

Reset
REQ-025 nrst=0 sampled at a clock edge SHALL load state=FETCH, overriding any in-progress access, including a wait in MEM_RD/MEM_WR.
REQ-026 While nrst=0, all outputs SHALL be forced to 0 combinationally.

Configuration
REQ-027 With MC_CTRL_MEM_WAIT_EN defined, mem_ready SHALL gate FETCH, MEM_RD and MEM_WR as specified above.
REQ-028 Without MC_CTRL_MEM_WAIT_EN, mem_ready SHALL be ignored and treated as 1, making every memory state exactly one cycle; the port SHALL remain present.

Structure
REQ-029 Opcode constants and the state encoding SHALL live in the shared package mips_pkg.
REQ-030 The block SHALL be a single module with no sub-modules; next-state logic and output decode SHALL be separate always blocks.

Verification
REQ-031 Reset: hold nrst=0 for 2 cycles, then release -> outputs 0 during reset; state=0 on the first cycle after release; mem_read=1.
REQ-032 Instruction sequence with mem_ready=1: lw(100011), sw(101011), R(000000), addi(001000) -> state traces 0,1,2,3,4 / 0,1,2,5 / 0,1,6,7 / 0,1,10,11; one retire per instruction.
REQ-033 beq(000100) with zero=1, then with zero=0 -> pc_en=1 in BRANCH, then pc_en=0; pc_source=01 in both.
REQ-034 Illegal opcode 111111 -> illegal pulses for one cycle in DECODE; next state FETCH; no retire.
REQ-035 With MC_CTRL_MEM_WAIT_EN: lw with mem_ready=0 for 3 cycles in MEM_RD -> state held at 3 for 3 cycles, MEM_WB reached on the 4th; a second build without the macro -> same stimulus completes in 5 cycles.
REQ-036 Mid-operation reset: nrst=0 while in MEM_RD with mem_ready=0 -> state=0 next cycle; no reg_write or retire.
